adder_sequencer: RTL

Controller that sequences the two-adder datapath (ripple-carry and carry-lookahead adders feeding a shared 10-bit load register through a select mux) through a full compare operation. It accepts a 4-bit operand pair and carry-in on a start pulse and drives the datapath's `load`, `select`, `A`, `B` and `Cin` through a fixed five-state schedule. It captures the RCA result, then the CLA result, and checks both against an internal golden sum. It keeps operation and error counters for self-test of the adder pair.

---
 rtl/adder_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/adder_sequencer.sv
// Five-state controller that drives an RCA/CLA adder pair through a compare
// operation. It captures both sums and checks them against a golden sum.
module adder_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic [9:0] dp_s,
    output logic       dp_load,
    output logic       dp_select,
    output logic [3:0] dp_a,
    output logic [3:0] dp_b,
    output logic       dp_cin,
    output logic       busy,
    output logic       done,
    output logic [4:0] sum_rca,
    output logic [4:0] sum_cla,
    output logic       rca_err,
    output logic       cla_err,
    output logic [7:0] op_count,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_PR,
        S_PC,
        S_CC
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  a_q, a_d, b_q, b_d;
    logic        cin_q, cin_d;
    logic        load_q, load_d, select_q, select_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [4:0]  sum_rca_q, sum_rca_d, sum_cla_q, sum_cla_d;
    logic        rca_bad_q, rca_bad_d;
    logic        rca_err_q, rca_err_d, cla_err_q, cla_err_d;
    logic [7:0]  op_count_q, op_count_d, err_count_q, err_count_d;
    logic [4:0]  golden;
    logic        cla_bad;

    assign golden = {1'b0, a_q} + {1'b0, b_q} + {4'b0, cin_q};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        load_d      = load_q;
        select_d    = select_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sum_rca_d   = sum_rca_q;
        sum_cla_d   = sum_cla_q;
        rca_bad_d   = rca_bad_q;
        rca_err_d   = rca_err_q;
        cla_err_d   = cla_err_q;
        op_count_d  = op_count_q;
        err_count_d = err_count_q;
        cla_bad     = 1'b0;

        // load/select are decoded from the next state, so they behave as a Moore decode of state_q.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    cin_d    = cin;
                    busy_d   = 1'b1;
                    state_d  = S_LD;
                    load_d   = 1'b1;
                    select_d = 1'b0;
                end
            end
            S_LD: begin
                state_d  = S_PR;
                load_d   = 1'b1;
                select_d = 1'b0;
            end
            S_PR: begin
                state_d  = S_PC;
                load_d   = 1'b1;
                select_d = 1'b1;
            end
            S_PC: begin
                state_d   = S_CC;
                load_d    = 1'b0;
                select_d  = 1'b0;
                sum_rca_d = dp_s[4:0];
                rca_bad_d = (dp_s[4:0] != golden) || (dp_s[9:5] != 5'd0);
            end
            S_CC: begin
                cla_bad    = (dp_s[9:5] != golden) || (dp_s[4:0] != 5'd0);
                state_d    = S_IDLE;
                sum_cla_d  = dp_s[9:5];
                rca_err_d  = rca_bad_q;
                cla_err_d  = cla_bad;
                op_count_d = op_count_q + 8'd1;
                if ((rca_bad_q || cla_bad) && err_count_q != 8'hff)
                    err_count_d = err_count_q + 8'd1;
                done_d     = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                load_d   = 1'b0;
                select_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            load_q      <= 1'b0;
            select_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_rca_q   <= '0;
            sum_cla_q   <= '0;
            rca_bad_q   <= 1'b0;
            rca_err_q   <= 1'b0;
            cla_err_q   <= 1'b0;
            op_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            load_q      <= load_d;
            select_q    <= select_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sum_rca_q   <= sum_rca_d;
            sum_cla_q   <= sum_cla_d;
            rca_bad_q   <= rca_bad_d;
            rca_err_q   <= rca_err_d;
            cla_err_q   <= cla_err_d;
            op_count_q  <= op_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign dp_load   = load_q;
    assign dp_select = select_q;
    assign dp_a      = a_q;
    assign dp_b      = b_q;
    assign dp_cin    = cin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_rca   = sum_rca_q;
    assign sum_cla   = sum_cla_q;
    assign rca_err   = rca_err_q;
    assign cla_err   = cla_err_q;
    assign op_count  = op_count_q;
    assign err_count = err_count_q;

endmodule
